uart_tx_serial: RTL

Byte-oriented UART transmitter, the transmit-side counterpart of `uart_rx_serial`, driving 8N1 (or 8E1 with parity compiled in) frames onto the PL header pin toward the USB-UART RX. It accepts one byte per valid/ready handshake, serialises it LSB-first at a fixed baud derived from the 50 MHz PL clock, and is used to return pipeline status and book snapshots to the host.

---
 rtl/uart_tx_serial.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serial.sv
// Purpose : 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined), LSB first, fixed baud.
// Latency : start bit drives the line from the accept edge; a frame lasts 10 (11) bit periods.
// Backpr. : tx_ready is low for the whole frame; tx_valid/tx_data are ignored until it returns.
//
// Ports:
//   clk        core clock, single domain
//   rst_n      asynchronous active-low reset
//   tx_valid   byte offered on tx_data
//   tx_data    byte to transmit
//   tx_ready   transmitter accepts a byte this cycle (registered)
//   tx_serial  UART line, idle high (registered)
//   tx_busy    frame in progress, always !tx_ready (registered)
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.

module uart_tx_serial #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       tx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_serial: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   baud_cnt, baud_nxt;
    logic [2:0]      bit_idx, bit_nxt;
    logic [7:0]      shift, shift_nxt;
    logic            serial_nxt;
    logic            ready_nxt;
    logic            bit_end;
`ifdef UART_TX_PARITY_EN
    // Parity is captured at accept because the shift register is consumed while sending.
    logic            par_bit, par_nxt;
`endif

    assign bit_end = (baud_cnt == LAST_CNT);

    always_comb begin
        state_nxt  = state;
        baud_nxt   = bit_end ? '0 : baud_cnt + 1'b1;
        bit_nxt    = bit_idx;
        shift_nxt  = shift;
        serial_nxt = tx_serial;
        ready_nxt  = tx_ready;
`ifdef UART_TX_PARITY_EN
        par_nxt    = par_bit;
`endif
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (tx_valid && tx_ready) begin
                    state_nxt  = START;
                    shift_nxt  = tx_data;
                    bit_nxt    = 3'd0;
                    serial_nxt = 1'b0;
                    ready_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_nxt    = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt  = DATA;
                    serial_nxt = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt  = PARITY;
                        serial_nxt = par_bit;
`else
                        state_nxt  = STOP;
                        serial_nxt = 1'b1;
`endif
                    end else begin
                        bit_nxt    = bit_idx + 3'd1;
                        // Registered output: present the next bit, i.e. what shift[0] becomes.
                        serial_nxt = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt  = STOP;
                    serial_nxt = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_nxt  = IDLE;
                    serial_nxt = 1'b1;
                    ready_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                serial_nxt = 1'b1;
                ready_nxt  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'd0;
            tx_serial <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_idx   <= bit_nxt;
            shift     <= shift_nxt;
            tx_serial <= serial_nxt;
            tx_ready  <= ready_nxt;
            tx_busy   <= !ready_nxt;
`ifdef UART_TX_PARITY_EN
            par_bit   <= par_nxt;
`endif
        end
    end

endmodule
